// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the load/store path and the data-memory controller.
//   funct3 load/store encodings (instruction[14:12]), opcode constants used by the
//   control unit, and the dmem_ctrl FSM state encoding.
package riscv_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;
endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: DEPTH_WORDS x 32 data storage, byte-enabled synchronous write, combinational read.
//   clk   - write clock
//   we    - write enable
//   be    - per-byte lane write enable
//   idx   - word index (shared by read and write)
//   wdata - write data, lane-aligned
//   rdata - word at idx
module dmem_sram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory controller with wait states, alignment/range checks,
//   byte-lane steering and load extension.
//   clk, rst_n          - clock, asynchronous active-low reset
//   mem_read, mem_write - load / store request (sampled only in IDLE)
//   funct3, addr, wdata - access size/sign, byte address, store data
//   rdata, ready, err   - load result and error, both qualified by the one-cycle ready strobe
//   busy                - controller is not IDLE
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

    logic        f3_ok, misal, oor, bad, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata, shifted, load_val;

    dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .idx   (addr_q[AW+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_comb begin
        f3_ok = rd_q ? (f3_q inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                     : (f3_q inside {F3_SB, F3_SH, F3_SW});
        // f3[1:0] gives the size for every legal encoding (01 half, 10 word)
        misal = ((f3_q[1:0] == 2'b01) && addr_q[0]) || ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        oor   = {2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS);
        bad   = (rd_q && wr_q) || !f3_ok || misal || oor;
        // Move the addressed byte/half down to bit 0 before extension
        shifted   = mem_rdata >> {addr_q[1:0], 3'b000};
        load_val  = f3_q == F3_LB  ? {{24{shifted[7]}}, shifted[7:0]} :
                    f3_q == F3_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                    f3_q == F3_LW  ? mem_rdata :
                    f3_q == F3_LBU ? {24'd0, shifted[7:0]} :
                    f3_q == F3_LHU ? {16'd0, shifted[15:0]} : 32'd0;
        // Replicate store data across lanes; byte enables pick the addressed lanes
        mem_wdata = f3_q == F3_SB ? {4{wdata_q[7:0]}} : f3_q == F3_SH ? {2{wdata_q[15:0]}} : wdata_q;
        mem_be    = f3_q == F3_SB ? 4'b0001 << addr_q[1:0] :
                    f3_q == F3_SH ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        mem_we    = (state_q == ST_WAIT) && (cnt_q == 4'd0) && wr_q && !bad;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    err_d   = bad;
                    rdata_d = (rd_q && !bad) ? load_val : 32'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;
    assign ready = state_q == ST_RESP;
    assign busy  = state_q != ST_IDLE;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed-vector bench for dmem_ctrl at WAIT_CYCLES = 0, 1 and 3 (shared inputs).
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [2:0]  rdy, er, bsy;
    logic [31:0] rd [3];

    int vectors = 0, errs = 0;
    int lat [3], wid [3];
    bit bbad [3];
    bit zero_bad;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rd[0]), .ready(rdy[0]), .err(er[0]), .busy(bsy[0]));
    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rd[1]), .ready(rdy[1]), .err(er[1]), .busy(bsy[1]));
    dmem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rd[2]), .ready(rdy[2]), .err(er[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_read = r; mem_write = w; funct3 = f3; addr = a; wdata = d;
    endtask

    task automatic drop();
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    endtask

    // Issue one request to all three controllers and observe 8 edges.
    task automatic access(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req(r, w, f3, a, d);
        @(posedge clk);
        #1;
        drop();
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; wid[k] = 0; bbad[k] = !bsy[k];
        end
        zero_bad = 1'b0;
        last_rdata = 32'hxxxxxxxx;
        last_err = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rdy[k]) begin
                    if (lat[k] == 0) lat[k] = n;
                    wid[k]++;
                    if (!bsy[k]) bbad[k] = 1'b1;
                end else begin
                    if (lat[k] == 0 && !bsy[k]) bbad[k] = 1'b1;
                    if (rd[k] != 32'd0 || er[k]) zero_bad = 1'b1;
                end
            end
            if (rdy[1]) begin
                last_rdata = rd[1];
                last_err = er[1];
            end
        end
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
        access(1'b1, 1'b0, f3, a, 32'd0);
        chk({tag, "_rdata"}, last_rdata, exp_d);
        chk({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_e});
    endtask

    task automatic store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_e);
        access(1'b0, 1'b1, f3, a, d);
        chk({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_e});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {29'd0, rdy}, 32'd0);
        chk("rst_err",   {29'd0, er},  32'd0);
        chk("rst_busy",  {29'd0, bsy}, 32'd0);
        chk("rst_rdata", rd[1], 32'd0);
        rst_n = 1'b1;

        store("sw_10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("sw_lat_w1", lat[1], 2);
        load("lw_10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        chk("lw_lat_w1", lat[1], 2);
        chk("lat_w0", lat[0], 1);
        chk("lat_w3", lat[2], 4);
        chk("wid_w0", wid[0], 1);
        chk("wid_w1", wid[1], 1);
        chk("wid_w3", wid[2], 1);
        chk("busy_w0", {31'd0, bbad[0]}, 32'd0);
        chk("busy_w3", {31'd0, bbad[2]}, 32'd0);
        chk("idle_zero", {31'd0, zero_bad}, 32'd0);

        store("sb_11", 3'b000, 32'h11, 32'h000000A5, 1'b0);
        load("lb_11",  3'b000, 32'h11, 32'hFFFFFFA5, 1'b0);
        load("lbu_11", 3'b100, 32'h11, 32'h000000A5, 1'b0);
        load("lw_10b", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);
        load("lh_12",  3'b001, 32'h12, 32'hFFFFDEAD, 1'b0);
        load("lhu_12", 3'b101, 32'h12, 32'h0000DEAD, 1'b0);
        load("lhu_10", 3'b101, 32'h10, 32'h0000A5EF, 1'b0);
        load("lb_13",  3'b000, 32'h13, 32'hFFFFFFDE, 1'b0);

        load("lh_13_mis", 3'b001, 32'h13, 32'h0, 1'b1);
        store("sw_12_mis", 3'b010, 32'h12, 32'h12345678, 1'b1);
        load("lw_10c", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);
        load("lw_400_oor", 3'b010, 32'h400, 32'h0, 1'b1);
        access(1'b1, 1'b1, 3'b010, 32'h10, 32'h0);
        chk("both_err", {31'd0, last_err}, 32'd1);
        chk("both_rdata", last_rdata, 32'd0);
        load("lw_10d", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);
        load("ld_f3_011", 3'b011, 32'h10, 32'h0, 1'b1);
        store("st_f3_100", 3'b100, 32'h10, 32'h0, 1'b1);
        load("lw_10e", 3'b010, 32'h10, 32'hDEADA5EF, 1'b0);
        store("sh_16", 3'b001, 32'h16, 32'h0000BEEF, 1'b0);
        store("sh_14", 3'b001, 32'h14, 32'h00001234, 1'b0);
        load("lw_14", 3'b010, 32'h14, 32'hBEEF1234, 1'b0);
        chk("idle_zero2", {31'd0, zero_bad}, 32'd0);

        store("sw_20", 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
        req(1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111);
        @(posedge clk);
        #1;
        drop();
        chk("abort_busy_pre", {31'd0, bsy[1]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, rdy[1]}, 32'd0);
        chk("abort_err",   {31'd0, er[1]},  32'd0);
        chk("abort_rdata", rd[1], 32'd0);
        chk("abort_busy",  {29'd0, bsy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        load("lw_20", 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words of data memory.
REQ-002 Parameter WAIT_CYCLES, default 1, extra access wait states (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 mem_read  input  1  load request from control unit (MemRead).
REQ-006 mem_write  input  1  store request from control unit (MemWrite).
REQ-007 funct3  input  3  access size/sign from instruction[14:12].
REQ-008 addr  input  32  byte address (ALU result).
REQ-009 wdata  input  32  store data (rs2), bytes taken from low lanes.
REQ-010 rdata  output  32  load result, sign/zero-extended, valid only while ready=1.
REQ-011 ready  output  1  one-cycle completion strobe for the accepted request.
REQ-012 err  output  1  request rejected (illegal funct3, misaligned, out of range, or both requests); valid while ready=1.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 In IDLE, a rising edge with mem_read|mem_write=1 SHALL accept the request, latch op, funct3, addr, wdata, load the wait counter with WAIT_CYCLES, and go to WAIT.
REQ-016 In WAIT, the counter SHALL decrement each edge while nonzero; at the edge where it is zero the access SHALL be performed and the FSM SHALL go to RESP.
REQ-017 ready SHALL be asserted for exactly one cycle (RESP), beginning WAIT_CYCLES+1 edges after the accepting edge; RESP SHALL always return to IDLE on the next edge.
REQ-018 Inputs SHALL be ignored outside IDLE; the requester SHALL deassert its request during the ready cycle, otherwise a request high in IDLE is a new request.
REQ-019 Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-020 Stores: 000 SB, 001 SH, 010 SW; only addressed byte lanes SHALL be written; other lanes unchanged.
REQ-021 Halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL set err, suppress the write, and return rdata=0.
REQ-022 Word index addr[31:2] >= DEPTH_WORDS SHALL set err, suppress the write, and return rdata=0 (no wrap-around).
REQ-023 Unlisted funct3 for the requested op SHALL set err with no memory effect.
REQ-024 mem_read and mem_write both high at acceptance SHALL set err with no memory effect.
REQ-025 rdata SHALL be 0 and err SHALL be 0 whenever ready=0.
REQ-026 Store-then-load to the same address SHALL return the stored data (no stale read).

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ready=0, err=0, busy=0, rdata=0, counter=0.
REQ-028 Reset during WAIT SHALL abort the request; a store not yet performed SHALL not modify memory.
REQ-029 Memory array contents SHALL NOT be reset.

Structure
REQ-030 Shared package riscv_pkg SHALL hold funct3 load/store encodings, opcode constants shared with the control unit, and the FSM state encoding.
REQ-031 Storage SHALL be a sub-module dmem_sram: DEPTH_WORDS x 32, synchronous write with 4-bit byte enable, combinational or single-cycle read.
REQ-032 dmem_ctrl SHALL contain FSM, wait counter, alignment/range check, byte-lane steering and extension logic.

Verification
REQ-033 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> ready 2 edges after acceptance (WAIT_CYCLES=1), rdata=0xDEADBEEF, err=0.
REQ-034 After REQ-033, SB 0x11 wdata=0x000000A5; LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LW 0x10 -> 0xDEADA5EF.
REQ-035 LH 0x13 -> err=1, rdata=0; SW 0x12 wdata=0x12345678 -> err=1, LW 0x10 still 0xDEADA5EF.
REQ-036 LW addr=0x400 (DEPTH_WORDS=256) -> err=1, rdata=0; mem_read=mem_write=1 -> err=1, memory unchanged.
REQ-037 SW 0x20 wdata=0x11111111 with rst_n pulsed low during WAIT -> outputs zero immediately, busy=0; then LW 0x20 returns prior contents, not 0x11111111.
REQ-038 WAIT_CYCLES=0 and 3 -> ready asserted 1 and 4 edges after acceptance respectively, exactly one cycle wide, busy high throughout.
